vga_axil_regfile: RTL
=====================

VGA_AXIL_REGFILE -- requirements
Module: vga_axil_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, native data width (equals AXIL data width).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, native word address width (16 word slots).
REQ-003 SHALL have parameter ID_VALUE, default 32'h5647_4101, constant returned by the ID register.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 write_en  input  1  native write strobe from the AXIL slave FSM, one cycle per write.
REQ-007 addr_write  input  ADDR_WIDTH  native word write address.
REQ-008 data2native  input  DATA_WIDTH  write data.
REQ-009 read_en_sync  input  1  native read strobe, one cycle per read.
REQ-010 addr_read  input  ADDR_WIDTH  native word read address.
REQ-011 data2axil  output  DATA_WIDTH  registered read data.
REQ-012 vsync  input  1  frame sync from timing generator, same clock domain.
REQ-013 ctrl_en  output  1  display enable (CTRL[0]).
REQ-014 pattern_sel  output  2  test-pattern select (CTRL[3:2]).
REQ-015 irq  output  1  frame interrupt request.

Function
REQ-016 Register map (word addr): 0 CTRL RW bits[3:0], others read 0; 1 STATUS RO; 2 IRQ W1C bit0; 3 FRAME_CNT RO, write clears; 4 SCRATCH RW full width; 5 ID RO = ID_VALUE; 6..15 unmapped.
REQ-017 CTRL: bit0 enable, bit1 irq_en, bits[3:2] pattern_sel; ctrl_en and pattern_sel driven directly from CTRL flops.
REQ-018 Write SHALL take effect on the clk edge where write_en=1; new value visible to a read issued the next cycle.
REQ-019 Read: read_en_sync=1 at edge N -> data2axil holds addressed value from edge N until next read strobe; latency exactly 1 cycle.
REQ-020 data2axil SHALL hold its value when read_en_sync=0.
REQ-021 Simultaneous read and write to same address: read SHALL return pre-write value.
REQ-022 Unmapped/RO writes SHALL be ignored with no side effect; unmapped reads SHALL return 0.
REQ-023 vsync rising edge = vsync=1 and registered previous vsync=0; previous-vsync flop resets to 1 (no spurious edge on release).
REQ-024 On a vsync rising edge with CTRL.enable=1: FRAME_CNT increments by 1 and IRQ[0] sets; with enable=0 neither changes.
REQ-025 FRAME_CNT SHALL wrap 0xFFFF_FFFF -> 0 with no flag.
REQ-026 Any write to addr 3 SHALL clear FRAME_CNT to 0; clear wins over simultaneous increment (result 0).
REQ-027 Write to addr 2 with data bit0=1 clears IRQ[0]; bit0=0 no effect; simultaneous set and clear -> set wins.
REQ-028 STATUS: bit0 = IRQ[0], bit1 = CTRL.enable, bit2 = registered vsync; others 0.
REQ-029 irq = IRQ[0] AND CTRL.irq_en, combinational from flops only.

Reset
REQ-030 While arst_n=0: CTRL, IRQ, FRAME_CNT, SCRATCH, data2axil = 0; ctrl_en=0, pattern_sel=0, irq=0; previous-vsync=1.
REQ-031 Reset asserted mid-transaction SHALL abort it; no partial write survives; strobes ignored until arst_n=1 sampled.

Verification
REQ-032 Reset then read addrs 0..5 -> 0,0,0,0,0,ID_VALUE; outputs all 0.
REQ-033 Write SCRATCH=0xDEAD_BEEF, CTRL=0xF -> read back 0xDEAD_BEEF, 0x0000_000F; ctrl_en=1, pattern_sel=3.
REQ-034 enable=1, irq_en=1, 3 vsync pulses -> FRAME_CNT=3, IRQ=1, irq=1; write IRQ=1 -> irq=0 next cycle; vsync edge coincident with clear -> IRQ stays 1.
REQ-035 Force FRAME_CNT to 0xFFFF_FFFF (via 2^32-1 edges or backdoor), one vsync -> 0; write addr 3 coincident with edge -> 0.
REQ-036 Write addr 9 and addr 5 with 0x1234 -> reads return 0 and ID_VALUE; same-cycle read/write SCRATCH returns old value.
REQ-037 Assert arst_n low 50 ns during writes/vsync activity -> all registers reset per REQ-030; post-reset random write/read traffic matches scoreboard.

Source files
------------

// File: rtl/vga_axil_regfile_if.sv
// Native-side register port between the AXI-Lite slave FSM and the
// VGA register file.
interface vga_axil_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] addr_write;
  logic [DATA_WIDTH-1:0] data2native;
  logic                  read_en_sync;
  logic [ADDR_WIDTH-1:0] addr_read;
  logic [DATA_WIDTH-1:0] data2axil;

  modport master (
    output write_en,
    output addr_write,
    output data2native,
    output read_en_sync,
    output addr_read,
    input  data2axil
  );

  modport slave (
    input  write_en,
    input  addr_write,
    input  data2native,
    input  read_en_sync,
    input  addr_read,
    output data2axil
  );
endinterface

// File: rtl/vga_axil_regfile.sv
// VGA control/status register file on the native AXI-Lite port.
// vsync rising edges advance the frame counter and raise the frame IRQ.
module vga_axil_regfile #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [31:0] ID_VALUE   = 32'h5647_4101
) (
  input  logic             clk,
  input  logic             arst_n,
  vga_axil_regfile_if.slave bus,
  input  logic             vsync,
  output logic             ctrl_en,
  output logic [1:0]       pattern_sel,
  output logic             irq
);
  localparam int DW = DATA_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t A_CTRL    = addr_t'(0);
  localparam addr_t A_STATUS  = addr_t'(1);
  localparam addr_t A_IRQ     = addr_t'(2);
  localparam addr_t A_FRAME   = addr_t'(3);
  localparam addr_t A_SCRATCH = addr_t'(4);
  localparam addr_t A_ID      = addr_t'(5);

  logic [3:0]    ctrl_q, ctrl_d;
  logic          irq_q, irq_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] scr_q, scr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          vs_prev_q, vs_prev_d;
  logic          vs_q, vs_d;

  logic          frame_tick;
  logic          w_ctrl, w_irq, w_cnt, w_scr;
  logic [DW-1:0] rd_val;

  assign frame_tick = vsync & ~vs_prev_q & ctrl_q[0];

  assign w_ctrl = bus.write_en && (bus.addr_write == A_CTRL);
  assign w_irq  = bus.write_en && (bus.addr_write == A_IRQ);
  assign w_cnt  = bus.write_en && (bus.addr_write == A_FRAME);
  assign w_scr  = bus.write_en && (bus.addr_write == A_SCRATCH);

  // Read mux sees only current flops, so a same-cycle write is not visible
  always_comb begin
    rd_val = '0;
    case (bus.addr_read)
      A_CTRL:    rd_val = DW'(ctrl_q);
      A_STATUS:  rd_val = DW'({vs_q, ctrl_q[0], irq_q});
      A_IRQ:     rd_val = DW'(irq_q);
      A_FRAME:   rd_val = cnt_q;
      A_SCRATCH: rd_val = scr_q;
      A_ID:      rd_val = DW'(ID_VALUE);
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    irq_d     = irq_q;
    cnt_d     = cnt_q;
    scr_d     = scr_q;
    rdata_d   = rdata_q;
    vs_prev_d = vsync;
    vs_d      = vsync;

    if (frame_tick) begin
      cnt_d = cnt_q + DW'(1);
    end

    unique case (1'b1)
      w_ctrl: ctrl_d = bus.data2native[3:0];
      w_irq: begin
        if (bus.data2native[0]) begin
          irq_d = 1'b0;
        end
      end
      w_cnt: cnt_d = '0;
      w_scr: scr_d = bus.data2native;
      default: ;
    endcase

    // Applied after the W1C so a coincident frame edge wins
    if (frame_tick) begin
      irq_d = 1'b1;
    end

    if (bus.read_en_sync) begin
      rdata_d = rd_val;
    end
  end

  // vs_prev resets high so a vsync already high at release is no edge
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_q    <= '0;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
      scr_q     <= '0;
      rdata_q   <= '0;
      vs_prev_q <= 1'b1;
      vs_q      <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
      scr_q     <= scr_d;
      rdata_q   <= rdata_d;
      vs_prev_q <= vs_prev_d;
      vs_q      <= vs_d;
    end
  end

  assign bus.data2axil = rdata_q;
  assign ctrl_en       = ctrl_q[0];
  assign pattern_sel   = ctrl_q[3:2];
  assign irq           = irq_q & ctrl_q[1];
endmodule
